// File: rtl/seqdec_prog.sv
// Programmable serial sequence detector: matches the last PAT_W valid bits against a
// masked pattern, with run-time overlap mode and a saturating match counter.
module seqdec_prog #(
    parameter int               PAT_W   = 8,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(8'h45)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Inp,
    input  logic             In_vld,
    input  logic             Cfg_load,
    input  logic [PAT_W-1:0] Cfg_pat,
    input  logic [PAT_W-1:0] Cfg_mask,
    input  logic             Cfg_ovl,
    input  logic             Clr_cnt,
    output logic             Out,
    output logic [CNT_W-1:0] Match_cnt,
    output logic             Filled
);
    localparam int            FW   = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    logic [PAT_W-1:0] hist, pat, mask;
    logic             ovl;
    logic [FW-1:0]    fill;

    logic [PAT_W-1:0] window, hist_nxt;
    logic [FW-1:0]    fill_inc, fill_nxt;
    logic             hit;

    // The fill gate keeps reset/flush zeros in hist from ever producing a match.
    always_comb begin
        window   = {hist[PAT_W-2:0], Inp};
        fill_inc = (fill == FULL) ? FULL : fill + FW'(1);
        hit      = In_vld && !Cfg_load && (fill_inc == FULL) &&
                   (((window ^ pat) & mask) == '0);
        hist_nxt = hist;
        fill_nxt = fill;
        if (Cfg_load) begin
            hist_nxt = '0;
            fill_nxt = '0;
        end else if (In_vld) begin
            if (hit && !ovl) begin
                hist_nxt = '0;
                fill_nxt = '0;
            end else begin
                hist_nxt = window;
                fill_nxt = fill_inc;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hist   <= '0;
            fill   <= '0;
            Filled <= 1'b0;
            Out    <= 1'b0;
            pat    <= DEF_PAT;
            mask   <= '1;
            ovl    <= 1'b1;
        end else begin
            hist   <= hist_nxt;
            fill   <= fill_nxt;
            Filled <= (fill_nxt == FULL);
            Out    <= hit;
            if (Cfg_load) begin
                pat  <= Cfg_pat;
                mask <= Cfg_mask;
                ovl  <= Cfg_ovl;
            end
        end
    end

    // Clear beats increment; the count sticks at all ones.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            Match_cnt <= '0;
        else if (Clr_cnt)
            Match_cnt <= '0;
        else if (hit && (Match_cnt != '1))
            Match_cnt <= Match_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_seqdec_prog.sv
// Directed bench for seqdec_prog: an 8-bit and a 4-bit instance, each shadowed by a
// bit-history model, compared every cycle plus literal checkpoints.
module tb_seqdec_prog;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    logic       a_inp = 0, a_vld = 0, a_load = 0, a_ovl = 0, a_clr = 0;
    logic [7:0] a_pat = 0, a_mask = 0;
    logic       a_out, a_filled;
    logic [7:0] a_cnt;

    logic       b_inp = 0, b_vld = 0, b_load = 0, b_ovl = 0, b_clr = 0;
    logic [3:0] b_pat = 0, b_mask = 0;
    logic       b_out, b_filled;
    logic [1:0] b_cnt;

    seqdec_prog #(.PAT_W(8), .CNT_W(8), .DEF_PAT(8'h45)) dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .Inp(a_inp), .In_vld(a_vld), .Cfg_load(a_load),
        .Cfg_pat(a_pat), .Cfg_mask(a_mask), .Cfg_ovl(a_ovl), .Clr_cnt(a_clr),
        .Out(a_out), .Match_cnt(a_cnt), .Filled(a_filled));

    seqdec_prog #(.PAT_W(4), .CNT_W(2), .DEF_PAT(4'h9)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .Inp(b_inp), .In_vld(b_vld), .Cfg_load(b_load),
        .Cfg_pat(b_pat), .Cfg_mask(b_mask), .Cfg_ovl(b_ovl), .Clr_cnt(b_clr),
        .Out(b_out), .Match_cnt(b_cnt), .Filled(b_filled));

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the valid bits seen since the last restart, as an integer value plus a length.
    typedef struct packed {
        int w; int cmax; int val; int len; int pat; int mask; bit ovl; bit out; int cnt;
    } mdl_t;

    function automatic mdl_t mreset(input int w, input int defpat, input int cmax);
        mdl_t m;
        m.w = w; m.cmax = cmax; m.val = 0; m.len = 0; m.pat = defpat;
        m.mask = (1 << w) - 1; m.ovl = 1; m.out = 0; m.cnt = 0;
        return m;
    endfunction

    function automatic mdl_t mstep(input mdl_t mi, input bit inp, input bit vld,
                                   input bit load, input int cpat, input int cmask,
                                   input bit covl, input bit clr);
        mdl_t m = mi;
        bit hit = 0;
        if (load) begin
            m.pat = cpat; m.mask = cmask; m.ovl = covl; m.val = 0; m.len = 0;
        end else if (vld) begin
            m.val = ((m.val << 1) | int'(inp)) % (1 << m.w);
            m.len = (m.len < m.w) ? m.len + 1 : m.w;
            hit = (m.len == m.w) && (((m.val ^ m.pat) & m.mask) == 0);
            if (hit && !m.ovl) begin
                m.val = 0; m.len = 0;
            end
        end
        m.out = hit;
        if (clr) m.cnt = 0;
        else if (hit && m.cnt < m.cmax) m.cnt = m.cnt + 1;
        return m;
    endfunction

    mdl_t ma, mb;
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ma <= mreset(8, 'h45, 255);
            mb <= mreset(4, 'h9, 3);
        end else begin
            ma <= mstep(ma, a_inp, a_vld, a_load, int'(a_pat), int'(a_mask), a_ovl, a_clr);
            mb <= mstep(mb, b_inp, b_vld, b_load, int'(b_pat), int'(b_mask), b_ovl, b_clr);
        end
    end

    always @(negedge Clk) begin
        chk("a_out", int'(a_out), int'(ma.out));
        chk("a_cnt", int'(a_cnt), ma.cnt);
        chk("a_filled", int'(a_filled), int'(ma.len == ma.w));
        chk("b_out", int'(b_out), int'(mb.out));
        chk("b_cnt", int'(b_cnt), mb.cnt);
        chk("b_filled", int'(b_filled), int'(mb.len == mb.w));
    end

    // Inputs change 2 time units after the rising edge, well clear of both edges.
    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic feed_a(input bit b);
        a_inp = b; a_vld = 1; tick(); a_vld = 0;
    endtask

    task automatic feed_b(input bit b);
        b_inp = b; b_vld = 1; tick(); b_vld = 0;
    endtask

    task automatic load_a(input logic [7:0] p, input logic [7:0] m, input bit o);
        a_pat = p; a_mask = m; a_ovl = o; a_load = 1; a_clr = 1; tick(); a_load = 0; a_clr = 0;
    endtask

    task automatic pulse_reset();
        Reset_n = 0; tick(); Reset_n = 1;
    endtask

    logic [127:0] stream = 128'h0026_A352_F545_9793_4578_26A5_2937_82AB;
    logic [7:0]   byte_v;
    int           n_hi;

    initial begin
        tick(); tick();
        chk("rst_out", int'(a_out), 0);
        chk("rst_cnt", int'(a_cnt), 0);
        chk("rst_filled", int'(a_filled), 0);
        Reset_n = 1;

        // Default pattern 0x45 over the long stream: two occurrences.
        for (int i = 0; i < 128; i++) feed_a(stream[127-i]);
        a_inp = 0; tick();
        chk("stream_cnt", int'(a_cnt), 2);

        // Alternating bits against 0xAA, overlapping then non-overlapping.
        load_a(8'hAA, 8'hFF, 1'b1);
        n_hi = 0;
        for (int i = 0; i < 12; i++) begin
            feed_a(i % 2 == 0);
            n_hi += int'(a_out);
        end
        chk("aa_ovl_pulses", n_hi, 3);
        chk("aa_ovl_cnt", int'(a_cnt), 3);
        load_a(8'hAA, 8'hFF, 1'b0);
        for (int i = 0; i < 12; i++) begin
            feed_a(i % 2 == 0);
            if (i == 7) chk("aa_novl_8th", int'(a_out), 1);
        end
        chk("aa_novl_cnt", int'(a_cnt), 1);

        // All-zero pattern right after reset needs 8 real zeros.
        pulse_reset();
        load_a(8'h00, 8'hFF, 1'b1);
        for (int i = 0; i < 7; i++) feed_a(1'b0);
        chk("zero_7_out", int'(a_out), 0);
        chk("zero_7_filled", int'(a_filled), 0);
        feed_a(1'b0);
        chk("zero_8_out", int'(a_out), 1);
        chk("zero_8_filled", int'(a_filled), 1);

        // Masked compare: only the high nibble matters.
        load_a(8'hF0, 8'hF0, 1'b1);
        byte_v = 8'b1111_0110;
        for (int i = 7; i >= 0; i--) feed_a(byte_v[i]);
        chk("mask_hit", int'(a_out), 1);
        load_a(8'hF0, 8'hF0, 1'b1);
        byte_v = 8'b0111_0000;
        for (int i = 7; i >= 0; i--) feed_a(byte_v[i]);
        chk("mask_miss", int'(a_out), 0);

        // Gapped valid: idle cycles carry junk on Inp that must not shift in.
        load_a(8'h45, 8'hFF, 1'b1);
        byte_v = 8'h45;
        for (int i = 7; i >= 0; i--) begin
            feed_a(byte_v[i]);
            if (i == 0) chk("gap_hit", int'(a_out), 1);
            a_inp = ~byte_v[i];
            tick();
            if (i == 0) chk("gap_idle", int'(a_out), 0);
        end
        chk("gap_cnt", int'(a_cnt), 1);

        // 4-bit instance: saturation, clear on a match edge, reset mid-stream.
        b_pat = 4'h5; b_mask = 4'hF; b_ovl = 1; b_load = 1; tick(); b_load = 0;
        for (int i = 0; i < 20; i++) feed_b(i % 2 == 1);
        chk("sat_cnt", int'(b_cnt), 3);
        feed_b(1'b0);
        b_clr = 1; feed_b(1'b1); b_clr = 0;
        chk("clr_out", int'(b_out), 1);
        chk("clr_cnt", int'(b_cnt), 0);
        feed_b(1'b0); feed_b(1'b1);
        chk("post_clr_cnt", int'(b_cnt), 1);
        Reset_n = 0;
        #1;
        chk("mid_rst_out", int'(b_out), 0);
        chk("mid_rst_cnt", int'(b_cnt), 0);
        chk("mid_rst_filled", int'(b_filled), 0);
        chk("mid_rst_a_cnt", int'(a_cnt), 0);
        tick();
        Reset_n = 1;
        feed_b(1'b0); feed_b(1'b1); feed_b(1'b0);
        chk("post_rst_nofill", int'(b_out), 0);
        feed_b(1'b1);
        chk("post_rst_old_pat", int'(b_out), 0);
        feed_b(1'b1); feed_b(1'b0); feed_b(1'b0); feed_b(1'b1);
        chk("post_rst_def_pat", int'(b_out), 1);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/seqdec_prog.md
Name: seqdec_prog

Overview:
Parametrised serial sequence detector, successor to the fixed-pattern 8-bit detector. It samples a serial bit stream and flags when the last PAT_W valid bits match a pattern. The pattern, a don't-care mask and the overlap mode are programmable at run time, and a saturating match counter is kept. It sits on a serial input path and feeds a pulse plus a count to downstream control/status logic.

Parameters:
PAT_W, 8, pattern/window width in bits (>=2)
CNT_W, 8, match counter width
DEF_PAT, 8'h45, pattern value loaded at reset (PAT_W bits)

Ports:
Clk  input  1  clock, all state on rising edge
Reset_n  input  1  asynchronous active-low reset
Inp  input  1  serial data bit, MSB of pattern arrives first
In_vld  input  1  Inp qualifier; bit sampled only when 1
Cfg_load  input  1  load Cfg_pat/Cfg_mask/Cfg_ovl this edge
Cfg_pat  input  PAT_W  new pattern
Cfg_mask  input  PAT_W  per-bit compare enable (1=compare, 0=don't care)
Cfg_ovl  input  1  1=overlapping detection, 0=non-overlapping
Clr_cnt  input  1  synchronous clear of Match_cnt
Out  output  1  registered one-cycle match pulse
Match_cnt  output  CNT_W  saturating count of matches
Filled  output  1  window holds PAT_W valid bits since last restart

Behaviour:
- Reset (Reset_n=0, async): shift reg=0, fill count=0, Filled=0, Out=0, Match_cnt=0, pattern=DEF_PAT, mask=all ones, ovl=1.
- State: shift reg hist[PAT_W-1:0], fill counter 0..PAT_W (saturating), config regs.
- Sample edge (In_vld=1, Cfg_load=0): window = {hist[PAT_W-2:0], Inp}; hist <= window; fill <= min(fill+1, PAT_W).
- Match condition: fill_next==PAT_W AND ((window ^ pat) & mask)==0.
- Out <= match condition at that edge. Out is therefore high for exactly the one cycle after the edge that sampled the last pattern bit. Out=0 after any edge without a sampled bit.
- In_vld=0: hist and fill hold; Out <= 0.
- Overlap mode 1: hist is kept after a match, so back-to-back matches are possible (e.g. pattern 0xAA matches every 2 bits once filled).
- Overlap mode 0: on a match, fill <= 0 and hist <= 0. The next match needs PAT_W fresh bits.
- Filled = (fill==PAT_W), registered.
- The fill gate prevents false matches on reset/flush history, including pat=0 with mask all ones.
- Cfg_load=1: pat/mask/ovl <= inputs; hist <= 0; fill <= 0; Out <= 0. Any In_vld bit on that edge is discarded (load wins). Match_cnt is unaffected.
- Mask all zeros: every sampled bit with fill_next==PAT_W matches. Subject to the ovl rule, in mode 0 that means one match per PAT_W bits.
- Match_cnt: +1 on each match edge, saturating at 2^CNT_W-1, with no wrap.
- Clr_cnt=1 has priority: Match_cnt <= 0 even if a match occurs on the same edge. Out still pulses.
- Reset asserted mid-stream: immediate return to reset values. The first match after release needs PAT_W new valid bits.

Test Plan:
- Default config, stream 128'h0026_A352_F545_9793_4578_26A5_2937_82AB with In_vld=1 -> Out pulses exactly once per window equal to 8'h45, one cycle after the last '1' of 0x45. Match_cnt equals the number of 0x45 windows; the bench checks against a golden shift model.
- Cfg_load pat=8'hAA, ovl=1, then 12 alternating bits 1010...: Out high after the 8th bit and again after the 10th and 12th -> Match_cnt=3. Repeat with ovl=0 -> single match after the 8th bit, Match_cnt=1.
- pat=8'h00, mask=8'hFF, right after reset, feed 7 zeros -> Out=0 and Filled=0. The 8th zero -> Out=1 and Filled=1.
- pat=8'hF0, mask=8'hF0, stream 1111_0110 -> match (low nibble ignored), Out=1. Stream 0111_0000 -> no match.
- In_vld toggled 1/0 every cycle while feeding 0x45 -> Out pulses once, one cycle after the 8th valid bit. Idle cycles shift nothing.
- PAT_W=4, CNT_W=2, pat=4'h5, mask all ones, ovl=1, 20 alternating bits -> Match_cnt stops at 3. Clr_cnt asserted on a match edge -> Match_cnt=0 and Out=1 that cycle. Reset_n pulsed mid-stream -> all outputs 0 at once and pattern back to DEF_PAT.
